// File: rtl/usb_gpx_pkg.sv
// ============================================================================
// usb_gpx_pkg : register map, edge bit indices and filter state encoding
//               shared by the GPX conditioner.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package usb_gpx_pkg;

    localparam logic [1:0] GPX_STATUS   = 2'd0;
    localparam logic [1:0] GPX_CONTROL  = 2'd1;
    localparam logic [1:0] GPX_EDGE_CAP = 2'd2;
    localparam logic [1:0] GPX_EDGE_CNT = 2'd3;

    localparam int GPX_RISE = 0;
    localparam int GPX_FALL = 1;

    typedef enum logic [0:0] {
        FLT_STABLE  = 1'b0,
        FLT_PENDING = 1'b1
    } flt_state_t;

endpackage

`default_nettype wire

// File: rtl/usb_gpx_filter.sv
// ============================================================================
// usb_gpx_filter : two-flop synchronizer plus run-length glitch filter for the
//                  GPX pin, with single-cycle rise/fall pulses.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module usb_gpx_filter
    import usb_gpx_pkg::*;
#(
    parameter int FILTER_CYCLES = 4,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] c_LAST = 8'(FILTER_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_clean;
    logic [7:0] r_cnt;
    flt_state_t r_state;

    logic w_diff;
    logic w_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RESET_LEVEL;
            r_sync2 <= RESET_LEVEL;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_diff = (r_sync2 != r_clean);
    // The edge that completes the run toggles the output, so the pulses are
    // valid on that same edge for the register file.
    assign w_hit  = w_diff && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FLT_STABLE;
            r_cnt   <= 8'd0;
            r_clean <= RESET_LEVEL;
        end else begin
            case (r_state)
                FLT_STABLE: begin
                    if (w_hit) begin
                        r_clean <= ~r_clean;
                    end else if (w_diff) begin
                        r_state <= FLT_PENDING;
                        r_cnt   <= 8'd1;
                    end
                end
                FLT_PENDING: begin
                    if (!w_diff || w_hit) begin
                        r_state <= FLT_STABLE;
                        r_cnt   <= 8'd0;
                        if (w_hit) begin
                            r_clean <= ~r_clean;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= FLT_STABLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign clean = r_clean;
    assign rise  = w_hit && !r_clean;
    assign fall  = w_hit &&  r_clean;

endmodule

`default_nettype wire

// File: rtl/usb_gpx_conditioner.sv
// ============================================================================
// usb_gpx_conditioner : filtered GPX level plus Avalon-MM edge capture, edge
//                       counter and level interrupt for the Nios II.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module usb_gpx_conditioner
    import usb_gpx_pkg::*;
#(
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 16,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        gpx_raw,
    output logic        gpx_clean,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic             r_readdata;
    logic [31:0]      r_rdata;
    logic             r_irq;
    logic [1:0]       r_ctrl;
    logic [1:0]       r_cap;
    logic [CNT_W-1:0] r_cnt;

    logic        w_clean;
    logic        w_rise;
    logic        w_fall;
    logic [31:0] w_rd;
    logic [1:0]  w_cap_kept;
    logic        w_wr_ctrl;
    logic        w_wr_cap;
    logic        w_wr_cnt;
    logic        w_unused_wdata;

    usb_gpx_filter #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .RESET_LEVEL   (RESET_LEVEL)
    ) u_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (gpx_raw),
        .clean   (w_clean),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    assign w_wr_ctrl      = write && (address == GPX_CONTROL);
    assign w_wr_cap       = write && (address == GPX_EDGE_CAP);
    assign w_wr_cnt       = write && (address == GPX_EDGE_CNT);
    assign w_unused_wdata = ^writedata[31:2];

    always_comb begin
        w_rd = '0;
        case (address)
            GPX_STATUS:   w_rd[0]   = w_clean;
            GPX_CONTROL:  w_rd[1:0] = r_ctrl;
            GPX_EDGE_CAP: w_rd[1:0] = r_cap;
            GPX_EDGE_CNT: w_rd      = 32'(r_cnt);
            default:      w_rd      = '0;
        endcase
    end

    // A new edge wins over a W1C of the same bit.
    assign w_cap_kept = w_wr_cap ? (r_cap & ~writedata[1:0]) : r_cap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl     <= 2'b00;
            r_cap      <= 2'b00;
            r_cnt      <= '0;
            r_irq      <= 1'b0;
            r_rdata    <= 32'd0;
            r_readdata <= 1'b0;
        end else begin
            r_readdata <= read;
            if (read) begin
                r_rdata <= w_rd;
            end
            if (w_wr_ctrl) begin
                r_ctrl <= writedata[1:0];
            end
            r_cap[GPX_RISE] <= w_cap_kept[GPX_RISE] | w_rise;
            r_cap[GPX_FALL] <= w_cap_kept[GPX_FALL] | w_fall;
            if (w_wr_cnt) begin
                r_cnt <= w_rise ? c_CNT_ONE : '0;
            end else if (w_rise) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            r_irq <= |(r_cap & r_ctrl);
        end
    end

    assign gpx_clean = w_clean;
    assign readdata  = r_rdata;
    assign irq       = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_usb_gpx_conditioner.sv
// ============================================================================
// tb_usb_gpx_conditioner : directed and randomized checks of the GPX
//                          conditioner against a run-length reference model.
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_usb_gpx_conditioner;

    localparam int FC = 4;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        gpx_raw = 1'b0;
    logic        gpx_clean;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    usb_gpx_conditioner #(
        .FILTER_CYCLES (FC),
        .CNT_W         (CW),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .gpx_raw   (gpx_raw),
        .gpx_clean (gpx_clean),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit run_cmp = 1'b0;

    // Reference model: raw pin history, synchronized-value history, registers
    bit          m_clean;
    bit          rq[$];
    bit          sq[$];
    bit [1:0]    m_ctrl;
    bit [1:0]    m_cap;
    int unsigned m_cnt;
    bit [31:0]   m_rd;
    bit          m_irq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_clean = 1'b0;
        rq.delete();
        sq.delete();
        rq.push_back(1'b0);
        rq.push_back(1'b0);
        for (int i = 0; i < FC; i++) sq.push_back(1'b0);
        m_ctrl = 2'b00;
        m_cap  = 2'b00;
        m_cnt  = 0;
        m_rd   = 32'd0;
        m_irq  = 1'b0;
    endfunction

    // The output flips once FC consecutive synchronized samples disagree with it;
    // the sample seen at the next edge is the pin value from two edges earlier.
    function automatic bit will_toggle();
        if (rq[rq.size()-2] == m_clean) return 1'b0;
        for (int i = 0; i < FC - 1; i++)
            if (sq[sq.size()-1-i] == m_clean) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit [31:0] model_reg(input bit [1:0] a);
        case (a)
            2'd0:    return {31'd0, m_clean};
            2'd1:    return {30'd0, m_ctrl};
            2'd2:    return {30'd0, m_cap};
            default: return m_cnt;
        endcase
    endfunction

    function automatic void model_step();
        bit tg;
        bit seen;
        bit rise;
        bit fall;
        bit irq_n;
        if (!reset_n) begin
            model_reset();
            return;
        end
        tg    = will_toggle();
        seen  = rq[rq.size()-2];
        rise  = tg && !m_clean;
        fall  = tg && m_clean;
        irq_n = |(m_cap & m_ctrl);
        if (read) m_rd = model_reg(address);
        if (write && address == 2'd1) m_ctrl = writedata[1:0];
        if (write && address == 2'd2) m_cap = m_cap & ~writedata[1:0];
        m_cap = m_cap | {fall, rise};
        if (write && address == 2'd3) m_cnt = rise ? 1 : 0;
        else                          m_cnt = (m_cnt + rise) % (1 << CW);
        if (tg) m_clean = ~m_clean;
        m_irq = irq_n;
        rq.push_back(gpx_raw);
        sq.push_back(seen);
        while (rq.size() > 8)      void'(rq.pop_front());
        while (sq.size() > FC + 4) void'(sq.pop_front());
    endfunction

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("clean", gpx_clean, m_clean);
            chk("irq", irq, m_irq);
            chk("readdata", readdata, m_rd);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic do_write(input bit [1:0] a, input bit [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic do_read(input bit [1:0] a);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    task automatic wait_toggle(input string nm);
        int k = 0;
        while (!will_toggle() && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int hold = 0;
        int r;
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        int r;
        model_reset();
        run_cmp = 1'b1;
        tick(3);
        reset_n = 1'b1;
        chk("rst_clean", gpx_clean, 32'd0);
        chk("rst_irq", irq, 32'd0);
        for (int a = 0; a < 4; a++) begin
            do_read(a[1:0]);
            chk($sformatf("rst_read%0d", a), readdata, 32'd0);
        end

        // 3-cycle glitch is filtered out
        gpx_raw = 1'b1; tick(3);
        gpx_raw = 1'b0; tick(8);
        chk("glitch_clean", gpx_clean, 32'd0);
        do_read(2'd2); chk("glitch_cap", readdata, 32'd0);
        do_read(2'd3); chk("glitch_cnt", readdata, 32'd0);

        // Clean step: output follows after 2 + FC cycles
        do_write(2'd1, 32'd1);
        gpx_raw = 1'b1;
        tick(5); chk("step_t5", gpx_clean, 32'd0);
        tick(1); chk("step_t6", gpx_clean, 32'd1);
        chk("irq_lag", irq, 32'd0);
        tick(1); chk("irq_set", irq, 32'd1);
        do_read(2'd2); chk("step_cap", readdata, 32'd1);
        do_read(2'd3); chk("step_cnt", readdata, 32'd1);
        do_write(2'd2, 32'd1);
        chk("irq_w1c_edge", irq, 32'd1);
        tick(1); chk("irq_clr", irq, 32'd0);

        // Counter wraps modulo 2^CW
        do_write(2'd3, 32'd0);
        for (int i = 0; i < 17; i++) begin
            gpx_raw = 1'b0; tick(6);
            gpx_raw = 1'b1; tick(6);
        end
        do_read(2'd3); chk("wrap_cnt", readdata, 32'd1);

        // Fall coincides with W1C of the fall bit
        gpx_raw = 1'b0;
        wait_toggle("fall_w1c");
        do_write(2'd2, 32'd2);
        do_read(2'd2); chk("fall_w1c_bit1", {31'd0, readdata[1]}, 32'd1);

        // Rise coincides with a count-clear write
        gpx_raw = 1'b1;
        wait_toggle("rise_clr");
        do_write(2'd3, 32'd0);
        do_read(2'd3); chk("rise_clr_cnt", readdata, 32'd1);

        // Reset in the middle of a pending filter run
        gpx_raw = 1'b0; tick(8);
        gpx_raw = 1'b1; tick(4);
        reset_n = 1'b0;
        model_reset();
        tick(2);
        chk("midrst_clean", gpx_clean, 32'd0);
        reset_n = 1'b1;
        do_read(2'd2); chk("midrst_cap", readdata, 32'd0);
        tick(10);
        chk("midrst_after", gpx_clean, 32'd1);
        do_read(2'd2); chk("midrst_cap2", readdata, 32'd1);
        do_read(2'd3); chk("midrst_cnt", readdata, 32'd1);

        // Randomized traffic against the model
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                gpx_raw = $urandom_range(0, 1);
                hold = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                model_reset();
                tick(1);
                reset_n = 1'b1;
            end
            r = $urandom_range(0, 9);
            address   = 2'($urandom_range(0, 3));
            writedata = $urandom;
            read      = (r < 3);
            write     = (r >= 3 && r < 5);
            tick(1);
            read  = 1'b0;
            write = 1'b0;
        end
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
